serial_subtractor_ctrl: RTL

- Bit-serial multi-bit subtractor controller: computes diff = a − b, WIDTH bits, LSB first, through one full_subtractor cell.
- FSM, bit counter and borrow flip-flop sequence the shared cell, one bit per clock.
- Start/done handshake; results held until the next accepted start.
- Area-cheap alternative to ripple subtractors in the Combinational_Circuits/Subtractors family.

---
 rtl/serial_subtractor_ctrl_pkg.sv | 12 +
 rtl/serial_subtractor_ctrl_full_subtractor.sv | 13 +
 rtl/serial_subtractor_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_ctrl_pkg.sv
// Shared types and constants for the bit-serial subtractor controller.
package sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int SUB_WIDTH_DEF = 8;

endpackage

// File: rtl/serial_subtractor_ctrl_full_subtractor.sv
// One-bit full subtractor: D = A - B - Bin, Bout set when the bit needs a borrow.
module full_subtractor (
   input  logic A,
   input  logic B,
   input  logic Bin,
   output logic D,
   output logic Bout
);

   assign D    = A ^ B ^ Bin;
   assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one shared full_subtractor cell, LSB first, start/done handshake.
// Optional SERIAL_SUB_OVF_EN adds a signed-overflow output held alongside diff.
module serial_subtractor_ctrl
   import sub_pkg::*;
#(
   parameter int WIDTH = SUB_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e state_q, state_d;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             borrow_q, borrow_d;
   logic [WIDTH-1:0] aSh_q, aSh_d;
   logic [WIDTH-1:0] bSh_q, bSh_d;
   logic [WIDTH-1:0] diffSh_q, diffSh_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;

   logic cellD, cellBout;
   logic lastBit;
   logic accept;

   assign lastBit = (cnt_q == LAST_BIT);
   assign accept  = start && (state_q != RUN);

   full_subtractor uCell (
      .A    (aSh_q[0]),
      .B    (bSh_q[0]),
      .Bin  (borrow_q),
      .D    (cellD),
      .Bout (cellBout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (lastBit) state_d = DONE;
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == RUN);
      done = (state_q == DONE);
   end

   // Shift/counter datapath; diff and bout only change on the final bit so they stay stable outside RUN.
   always_comb begin
      cnt_d    = cnt_q;
      borrow_d = borrow_q;
      aSh_d    = aSh_q;
      bSh_d    = bSh_q;
      diffSh_d = diffSh_q;
      diff_d   = diff_q;
      bout_d   = bout_q;
      if (accept) begin
         aSh_d    = a;
         bSh_d    = b;
         borrow_d = 1'b0;
         cnt_d    = '0;
      end else if (state_q == RUN) begin
         diffSh_d = {cellD, diffSh_q[WIDTH-1:1]};
         aSh_d    = aSh_q >> 1;
         bSh_d    = bSh_q >> 1;
         borrow_d = cellBout;
         if (lastBit) begin
            diff_d = {cellD, diffSh_q[WIDTH-1:1]};
            bout_d = cellBout;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         borrow_q <= 1'b0;
         aSh_q    <= '0;
         bSh_q    <= '0;
         diffSh_q <= '0;
         diff_q   <= '0;
         bout_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         borrow_q <= borrow_d;
         aSh_q    <= aSh_d;
         bSh_q    <= bSh_d;
         diffSh_q <= diffSh_d;
         diff_q   <= diff_d;
         bout_q   <= bout_d;
      end
   end

   assign diff = diff_q;
   assign bout = bout_q;

`ifdef SERIAL_SUB_OVF_EN
   // Operand signs are captured at start because the shift registers lose them while running.
   logic aMsb_q, aMsb_d;
   logic bMsb_q, bMsb_d;
   logic ovf_q, ovf_d;

   always_comb begin
      aMsb_d = aMsb_q;
      bMsb_d = bMsb_q;
      ovf_d  = ovf_q;
      if (accept) begin
         aMsb_d = a[WIDTH-1];
         bMsb_d = b[WIDTH-1];
      end else if ((state_q == RUN) && lastBit) begin
         ovf_d = (aMsb_q != bMsb_q) && (cellD != aMsb_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aMsb_q <= 1'b0;
         bMsb_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         aMsb_q <= aMsb_d;
         bMsb_q <= bMsb_d;
         ovf_q  <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

endmodule
